// File: rtl/config_word_packer_pkg.sv
// Shared definitions for the configuration word packer: session state
// encoding, big-endian byte-lane positions and a lane-insert helper.
package config_word_packer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pack_state_t;

  // Index of the byte that completes a word (counter wraps back to 0 after it)
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  // Bit position of each byte lane; byte 0 arrives first and is most significant
  localparam int unsigned LANE0_LSB = 24;
  localparam int unsigned LANE1_LSB = 16;
  localparam int unsigned LANE2_LSB = 8;
  localparam int unsigned LANE3_LSB = 0;

  // Return 'word' with 'data' placed in the lane selected by 'idx'
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    case (idx)
      2'd0:    result[LANE0_LSB +: 8] = data;
      2'd1:    result[LANE1_LSB +: 8] = data;
      2'd2:    result[LANE2_LSB +: 8] = data;
      default: result[LANE3_LSB +: 8] = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/config_idle_timer.sv
// Idle timer for the UART session: counts cycles without a received byte
// and flags the cycle on which the idle limit is reached.
module config_idle_timer #(
  parameter int TimeoutCycles = 4096,
  parameter int TimeoutWidth  = 13
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TimeoutWidth-1:0] LAST_COUNT = TimeoutWidth'(TimeoutCycles - 1);

  logic [TimeoutWidth-1:0] count;

  // Count idle cycles while enabled; a clear restarts the count, and the
  // count wraps to zero after the final cycle so a new session starts fresh
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST_COUNT) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/config_word_packer.sv
// Packs UART bytes big-endian into 32-bit configuration words and merges
// them with words written directly by the parallel host. Host writes win
// arbitration; a UART word that collides with one waits in a one-entry
// pending slot, and a further collision drops the word and flags Overrun.
module config_word_packer
  import config_word_packer_pkg::*;
#(
  parameter int TimeoutCycles = 4096,
  parameter int TimeoutWidth  = 13
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  input  logic [31:0] SelfWriteData,
  input  logic        SelfWriteStrobe,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        ComActive,
  output logic        Overrun
);

  pack_state_t state;
  logic [1:0]  byte_cnt;
  logic [31:0] packed_word;
  logic        pend_valid;
  logic [31:0] pend_data;

  logic        timer_expired;
  logic        timer_enable;
  logic        word_done;
  logic        timeout_exit;
  logic [31:0] next_word;

  assign timer_enable = (state == ACTIVE);

  config_idle_timer #(
    .TimeoutCycles (TimeoutCycles),
    .TimeoutWidth  (TimeoutWidth)
  ) u_idle_timer (
    .CLK     (CLK),
    .reset   (reset),
    .clear   (RxValid),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Word assembly view of this cycle: the word with the incoming byte merged
  // in, whether it completes a word, and whether the session times out
  // (a byte arriving on the expiry cycle keeps the session alive)
  always_comb begin
    next_word    = insert_byte(packed_word, byte_cnt, RxData);
    word_done    = RxValid && (byte_cnt == LAST_BYTE_IDX);
    timeout_exit = (state == ACTIVE) && timer_expired && !RxValid;
  end

  // Session state, byte packing, pending slot and output arbitration
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      packed_word <= 32'd0;
      pend_valid  <= 1'b0;
      pend_data   <= 32'd0;
      WriteData   <= 32'd0;
      WriteStrobe <= 1'b0;
      ComActive   <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      WriteStrobe <= 1'b0;

      case (state)
        IDLE: begin
          if (RxValid) begin
            state     <= ACTIVE;
            ComActive <= 1'b1;
            Overrun   <= 1'b0;
          end
        end
        default: begin
          if (timeout_exit) begin
            state     <= IDLE;
            ComActive <= 1'b0;
          end
        end
      endcase

      if (RxValid) begin
        byte_cnt    <= byte_cnt + 2'd1;
        packed_word <= next_word;
      end else if (timeout_exit) begin
        byte_cnt    <= 2'd0;
        packed_word <= 32'd0;
      end

      if (SelfWriteStrobe) begin
        WriteData   <= SelfWriteData;
        WriteStrobe <= 1'b1;
        if (word_done) begin
          if (!pend_valid) begin
            pend_data  <= next_word;
            pend_valid <= 1'b1;
          end else begin
            Overrun <= 1'b1;
          end
        end
      end else if (pend_valid) begin
        WriteData   <= pend_data;
        WriteStrobe <= 1'b1;
        if (word_done) begin
          pend_data <= next_word;
        end else begin
          pend_valid <= 1'b0;
        end
      end else if (word_done) begin
        WriteData   <= next_word;
        WriteStrobe <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_config_word_packer.sv
// Directed self-checking bench for config_word_packer, run with a short
// idle timeout so session-close behaviour is reached quickly.
module tb_config_word_packer;

  localparam int TimeoutCycles = 16;
  localparam int TimeoutWidth  = 5;

  logic        CLK;
  logic        reset;
  logic [7:0]  RxData;
  logic        RxValid;
  logic [31:0] SelfWriteData;
  logic        SelfWriteStrobe;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        ComActive;
  logic        Overrun;

  int tests_run;
  int fail_count;
  int strobe_count;
  int strobe_snap;
  bit dropped_seen;

  config_word_packer #(
    .TimeoutCycles (TimeoutCycles),
    .TimeoutWidth  (TimeoutWidth)
  ) dut (
    .CLK             (CLK),
    .reset           (reset),
    .RxData          (RxData),
    .RxValid         (RxValid),
    .SelfWriteData   (SelfWriteData),
    .SelfWriteStrobe (SelfWriteStrobe),
    .WriteData       (WriteData),
    .WriteStrobe     (WriteStrobe),
    .ComActive       (ComActive),
    .Overrun         (Overrun)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count every strobed word and watch for the word that must be dropped
  always @(negedge CLK) begin
    if (!reset && WriteStrobe) begin
      strobe_count++;
      if (WriteData === 32'h05060708) dropped_seen = 1'b1;
    end
  end

  // Drive one cycle of inputs, then settle just after the clock edge
  task automatic applyStimulus(input logic rx_valid, input logic [7:0] rx_data,
                               input logic self_strobe, input logic [31:0] self_data);
    RxValid         = rx_valid;
    RxData          = rx_data;
    SelfWriteStrobe = self_strobe;
    SelfWriteData   = self_data;
    @(posedge CLK);
    #1;
    RxValid         = 1'b0;
    RxData          = 8'h00;
    SelfWriteStrobe = 1'b0;
    SelfWriteData   = 32'h0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run       = 0;
    fail_count      = 0;
    strobe_count    = 0;
    dropped_seen    = 1'b0;
    reset           = 1'b1;
    RxValid         = 1'b0;
    RxData          = 8'h00;
    SelfWriteStrobe = 1'b0;
    SelfWriteData   = 32'h0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_data", WriteData, 32'h0);
    checkOutput("rst_strobe", {31'd0, WriteStrobe}, 32'd0);
    checkOutput("rst_active", {31'd0, ComActive}, 32'd0);
    checkOutput("rst_overrun", {31'd0, Overrun}, 32'd0);
    reset = 1'b0;
    idleCycles(2);

    // Basic packing: FA B0 FA B1
    applyStimulus(1'b1, 8'hFA, 1'b0, 32'h0);
    checkOutput("t1_active_rise", {31'd0, ComActive}, 32'd1);
    checkOutput("t1_no_early_strobe", {31'd0, WriteStrobe}, 32'd0);
    applyStimulus(1'b1, 8'hB0, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hFA, 1'b0, 32'h0);
    checkOutput("t1_byte3_no_strobe", {31'd0, WriteStrobe}, 32'd0);
    applyStimulus(1'b1, 8'hB1, 1'b0, 32'h0);
    checkOutput("t1_strobe", {31'd0, WriteStrobe}, 32'd1);
    checkOutput("t1_data", WriteData, 32'hFAB0FAB1);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0);
    checkOutput("t1_strobe_single", {31'd0, WriteStrobe}, 32'd0);

    // Session closes after TimeoutCycles idle cycles
    idleCycles(TimeoutCycles - 2);
    checkOutput("t1_active_before_timeout", {31'd0, ComActive}, 32'd1);
    idleCycles(1);
    checkOutput("t1_timeout", {31'd0, ComActive}, 32'd0);

    // Partial word abandoned by timeout, then a fresh word
    strobe_snap = strobe_count;
    applyStimulus(1'b1, 8'h11, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h22, 1'b0, 32'h0);
    idleCycles(TimeoutCycles - 1);
    checkOutput("t2_active_hold", {31'd0, ComActive}, 32'd1);
    idleCycles(1);
    checkOutput("t2_timeout", {31'd0, ComActive}, 32'd0);
    checkOutput("t2_no_strobe", strobe_count, strobe_snap);
    applyStimulus(1'b1, 8'hDE, 1'b0, 32'h0);
    checkOutput("t2_active_again", {31'd0, ComActive}, 32'd1);
    applyStimulus(1'b1, 8'hAD, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hBE, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hEF, 1'b0, 32'h0);
    checkOutput("t2_strobe", {31'd0, WriteStrobe}, 32'd1);
    checkOutput("t2_data", WriteData, 32'hDEADBEEF);

    // Host write collides with the completing UART word
    applyStimulus(1'b1, 8'hCA, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hFE, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hF0, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h0D, 1'b1, 32'h12345678);
    checkOutput("t3_self_strobe", {31'd0, WriteStrobe}, 32'd1);
    checkOutput("t3_self_data", WriteData, 32'h12345678);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0);
    checkOutput("t3_pend_strobe", {31'd0, WriteStrobe}, 32'd1);
    checkOutput("t3_pend_data", WriteData, 32'hCAFEF00D);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0);
    checkOutput("t3_quiet", {31'd0, WriteStrobe}, 32'd0);

    // Overrun: pending full, host writes every cycle, another word completes
    applyStimulus(1'b1, 8'h01, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h02, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h03, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h04, 1'b1, 32'hA5A5A5A5);
    checkOutput("t4_self1", WriteData, 32'hA5A5A5A5);
    checkOutput("t4_no_overrun_yet", {31'd0, Overrun}, 32'd0);
    applyStimulus(1'b1, 8'h05, 1'b1, 32'hA5A5A5A6);
    applyStimulus(1'b1, 8'h06, 1'b1, 32'hA5A5A5A7);
    applyStimulus(1'b1, 8'h07, 1'b1, 32'hA5A5A5A8);
    applyStimulus(1'b1, 8'h08, 1'b1, 32'h5A5A5A5A);
    checkOutput("t4_self_last", WriteData, 32'h5A5A5A5A);
    checkOutput("t4_overrun", {31'd0, Overrun}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0);
    checkOutput("t4_pend_strobe", {31'd0, WriteStrobe}, 32'd1);
    checkOutput("t4_pend_data", WriteData, 32'h01020304);
    applyStimulus(1'b0, 8'h00, 1'b0, 32'h0);
    checkOutput("t4_pend_drained", {31'd0, WriteStrobe}, 32'd0);
    idleCycles(TimeoutCycles - 2);
    checkOutput("t4_timeout", {31'd0, ComActive}, 32'd0);
    checkOutput("t4_overrun_sticky", {31'd0, Overrun}, 32'd1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 32'h0);
    checkOutput("t4_overrun_clear", {31'd0, Overrun}, 32'd0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hCC, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hDD, 1'b0, 32'h0);
    checkOutput("t4_new_word", WriteData, 32'hAABBCCDD);

    // Byte arriving exactly on the expiry cycle keeps the session alive
    idleCycles(TimeoutCycles - 1);
    checkOutput("t6_active_pre", {31'd0, ComActive}, 32'd1);
    applyStimulus(1'b1, 8'h11, 1'b0, 32'h0);
    checkOutput("t6_active_kept", {31'd0, ComActive}, 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h33, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h44, 1'b0, 32'h0);
    checkOutput("t6_strobe", {31'd0, WriteStrobe}, 32'd1);
    checkOutput("t6_data", WriteData, 32'h11223344);

    // Reset in the middle of a word
    applyStimulus(1'b1, 8'h55, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h66, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'h77, 1'b0, 32'h0);
    reset = 1'b1;
    #2;
    checkOutput("t5_rst_data", WriteData, 32'h0);
    checkOutput("t5_rst_strobe", {31'd0, WriteStrobe}, 32'd0);
    checkOutput("t5_rst_active", {31'd0, ComActive}, 32'd0);
    checkOutput("t5_rst_overrun", {31'd0, Overrun}, 32'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    strobe_snap = strobe_count;
    idleCycles(4);
    checkOutput("t5_no_strobe_after_rst", strobe_count, strobe_snap);
    checkOutput("t5_idle_after_rst", {31'd0, ComActive}, 32'd0);
    applyStimulus(1'b1, 8'h9A, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hBC, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hDE, 1'b0, 32'h0);
    applyStimulus(1'b1, 8'hF0, 1'b0, 32'h0);
    checkOutput("t5_data", WriteData, 32'h9ABCDEF0);
    idleCycles(2);
    checkOutput("t5_one_word", strobe_count, strobe_snap + 1);

    checkOutput("t4_dropped_never_seen", {31'd0, dropped_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/config_word_packer.md
CONFIG_WORD_PACKER -- requirements
Module: config_word_packer

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 4096, meaning idle cycles after the last UART byte before the session closes.
REQ-002 SHALL have parameter TimeoutWidth, default 13, meaning timeout counter width; it SHALL hold TimeoutCycles.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port RxData, input, 8, received UART byte.
REQ-006 SHALL have port RxValid, input, 1, one-cycle pulse qualifying RxData.
REQ-007 SHALL have port SelfWriteData, input, 32, parallel-host config word.
REQ-008 SHALL have port SelfWriteStrobe, input, 1, one-cycle pulse qualifying SelfWriteData.
REQ-009 SHALL have port WriteData, output, 32, word to the configuration FSM.
REQ-010 SHALL have port WriteStrobe, output, 1, one-cycle pulse qualifying WriteData.
REQ-011 SHALL have port ComActive, output, 1, UART session active; drives the FSM_Reset input of the configuration FSM.
REQ-012 SHALL have port Overrun, output, 1, sticky flag set when a packed UART word is dropped.

Function
REQ-013 SHALL have states IDLE and ACTIVE; ComActive = (state == ACTIVE), registered.
REQ-014 In IDLE, RxValid=1 SHALL move the block to ACTIVE, store that byte as byte 0, and raise ComActive on the next cycle.
REQ-015 Bytes SHALL pack big-endian: byte 0 to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0]; a 2-bit byte counter wraps 3->0.
REQ-016 On the 4th byte, the packed word SHALL be ready; WriteStrobe SHALL pulse on the cycle after that byte's RxValid, with WriteData valid in the same cycle.
REQ-017 In ACTIVE, the timeout counter SHALL clear on every RxValid and otherwise increment; at count TimeoutCycles-1 the block SHALL return to IDLE. On that transition: byte counter cleared, partial word discarded, ComActive low next cycle.
REQ-018 RxValid in the cycle the timeout expires SHALL take priority: the byte is accepted, the counter is cleared, and the state stays ACTIVE.
REQ-019 SelfWriteStrobe SHALL be accepted in any state; WriteData=SelfWriteData with WriteStrobe on the next cycle; it SHALL NOT affect state, byte counter or timeout.
REQ-020 Output arbitration: SelfWriteStrobe has highest priority, then the pending UART word, then a freshly completed UART word.
REQ-021 If a UART word completes in the same cycle as SelfWriteStrobe, the UART word SHALL enter a one-entry pending register. It SHALL be emitted on the first later cycle without SelfWriteStrobe.
REQ-022 If a UART word completes while pending is full and pending cannot drain that cycle, the new word SHALL be dropped and Overrun set.
REQ-023 Overrun SHALL clear only on reset or on an IDLE->ACTIVE transition.
REQ-024 WriteStrobe SHALL never be high for two words in one cycle; at most one word is emitted per cycle.
REQ-025 Pending-register contents SHALL survive a timeout and still be emitted.

Reset
REQ-026 When reset is asserted, the block SHALL asynchronously enter IDLE and clear the byte counter, timeout counter, pending-valid and packed data. Outputs: WriteData=0, WriteStrobe=0, ComActive=0, Overrun=0.
REQ-027 Reset mid-word or mid-pending SHALL discard all data; no WriteStrobe SHALL follow the reset release until new input arrives.

Structure
REQ-028 State encoding (IDLE=1'b0, ACTIVE=1'b1) and the big-endian byte-lane constants SHALL live in the shared config package.
REQ-029 The timeout counter SHALL be the sub-module config_idle_timer, with ports CLK, reset, clear, enable and expired.
REQ-030 Target size SHALL be 150-300 lines of RTL, with all outputs registered.

Verification
REQ-031 Reset, then bytes FA,B0,FA,B1 on consecutive cycles -> WriteData=32'hFAB0FAB1, with WriteStrobe one cycle after byte 4. ComActive SHALL rise the cycle after byte 1.
REQ-032 Send 2 bytes, then idle for TimeoutCycles -> ComActive falls with no strobe. A following DE,AD,BE,EF SHALL yield 32'hDEADBEEF, and ComActive SHALL rise again.
REQ-033 SelfWriteStrobe with 32'h12345678 in the same cycle as UART byte 4 of 32'hCAFEF00D -> 12345678 strobed at T+1, CAFEF00D at T+2.
REQ-034 Pending full, SelfWriteStrobe held every cycle, and another UART word completes -> Overrun=1 and that word never appears. Overrun SHALL clear at the next session start.
REQ-035 Assert reset after byte 3 -> all outputs 0 and no strobe after release. Then 4 new bytes SHALL produce exactly one correct word.
REQ-036 RxValid on the exact timeout-expiry cycle -> ComActive stays 1 and the byte lands in lane 0 of the new word.
